// File: rtl/bounce_generator_pkg.sv
// Shared definitions for the contact-bounce emulator and its stimulus helpers.
package bounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } bounce_state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // One Galois step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR, reusable by other stimulus blocks.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next LFSR value, advanced unconditionally every cycle
  always_comb begin
    state_d = lfsr_step(state_q);
  end

  // State register, reloaded with the seed on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= seed;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/bounce_generator.sv
// Mechanical-contact emulator: turns a clean level into a bouncy line with
// a programmable number of glitches, fixed or pseudo-random gaps, and a
// settle period before signalling completion.
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int unsigned BOUNCE_BITS  = 3,
  parameter int unsigned GAP_BITS     = 6,
  parameter int unsigned SETTLE_TICKS = 16,
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clock_enable,
  input  logic                   in_level,
  input  logic [BOUNCE_BITS-1:0] bounce_count,
  input  logic                   random_en,
  input  logic [GAP_BITS-1:0]    gap_len,
  output logic                   out_signal,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned EW       = BOUNCE_BITS + 1;
  localparam int unsigned SETTLE_W = $clog2(SETTLE_TICKS + 1);

  bounce_state_e         state_q, state_d;
  logic [GAP_BITS-1:0]   gap_q, gap_d;
  logic [EW-1:0]         edges_q, edges_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  target_q, target_d;
  logic                  out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [15:0]           lfsr;
  logic [GAP_BITS:0]     rnd_sum;
  logic [GAP_BITS-1:0]   gap_load;
  logic                  start;
  logic                  gap_fire;
  logic                  settle_fire;
  logic                  unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (LFSR_SEED),
    .state   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:GAP_BITS];
  assign rnd_sum        = {1'b0, lfsr[GAP_BITS-1:0]} + (GAP_BITS+1)'(1);

  // Gap length for the next load: random (saturating) or fixed (min 1)
  always_comb begin
    gap_load = gap_len;
    if (random_en) begin
      gap_load = rnd_sum[GAP_BITS] ? '1 : rnd_sum[GAP_BITS-1:0];
    end else if (gap_len == '0) begin
      gap_load = GAP_BITS'(1);
    end
  end

  assign start       = (state_q == ST_IDLE) && (in_level != out_q);
  assign gap_fire    = (state_q == ST_BOUNCE) && clock_enable && (gap_q == GAP_BITS'(1));
  assign settle_fire = (state_q == ST_SETTLE) && clock_enable && (settle_q == SETTLE_W'(1));

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      edges_q  <= '0;
      settle_q <= '0;
      target_q <= 1'b0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      edges_q  <= edges_d;
      settle_q <= settle_d;
      target_q <= target_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    edges_d  = edges_q;
    settle_d = settle_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = in_level;
          gap_d    = gap_load;
          edges_d  = {bounce_count, 1'b0};
          if (bounce_count == '0) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_W'(SETTLE_TICKS);
          end else begin
            state_d = ST_BOUNCE;
          end
        end
      end
      ST_BOUNCE: begin
        if (clock_enable) begin
          if (gap_q == GAP_BITS'(1)) begin
            gap_d   = gap_load;
            edges_d = edges_q - EW'(1);
            if (edges_q == EW'(1)) begin
              state_d  = ST_SETTLE;
              settle_d = SETTLE_W'(SETTLE_TICKS);
            end
          end else begin
            gap_d = gap_q - GAP_BITS'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (clock_enable) begin
          settle_d = settle_q - SETTLE_W'(1);
          if (settle_q == SETTLE_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output update: line level, busy flag and one-cycle done pulse
  always_comb begin
    out_d  = out_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      out_d  = in_level;
      busy_d = 1'b1;
    end
    // the last glitch lands on the registered target, closing out an even edge count
    if (gap_fire) begin
      out_d = (edges_q == EW'(1)) ? target_q : ~out_q;
    end
    if (settle_fire) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign out_signal = out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: edge schedule, settle timing,
// sparse ticks, ignored input changes, async reset and random gaps.
module tb_bounce_generator;

  localparam int unsigned BB = 3;
  localparam int unsigned GB = 6;
  localparam int unsigned ST = 16;

  logic          clk          = 1'b0;
  logic          reset_n      = 1'b0;
  logic          clock_enable = 1'b1;
  logic          in_level     = 1'b0;
  logic [BB-1:0] bounce_count = '0;
  logic          random_en    = 1'b0;
  logic [GB-1:0] gap_len      = 6'd3;
  logic          out_signal;
  logic          busy;
  logic          done;

  bounce_generator #(
    .BOUNCE_BITS  (BB),
    .GAP_BITS     (GB),
    .SETTLE_TICKS (ST),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clock_enable (clock_enable),
    .in_level     (in_level),
    .bounce_count (bounce_count),
    .random_en    (random_en),
    .gap_len      (gap_len),
    .out_signal   (out_signal),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   edge_cyc[$];
  logic edge_val[$];
  int   done_cyc[$];
  int   busy_rise = -1;
  int   busy_fall = -1;
  logic prev_out  = 1'b0;
  logic prev_busy = 1'b0;
  logic ce_sparse = 1'b0;
  int   ph        = 0;

  // Cycle monitor, 1ns after each rising edge; also paces clock_enable
  always @(posedge clk) begin
    #1;
    cyc++;
    if (out_signal !== prev_out) begin
      edge_cyc.push_back(cyc);
      edge_val.push_back(out_signal);
    end
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    if (done) done_cyc.push_back(cyc);
    prev_out  = out_signal;
    prev_busy = busy;
    ph++;
    clock_enable = ce_sparse ? (ph % 4 == 0) : 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    edge_cyc.delete();
    edge_val.delete();
    done_cyc.delete();
    busy_rise = -1;
    busy_fall = -1;
  endtask

  // Drive a new level after the monitor; the DUT sees it at edge k
  task automatic start_level(input logic lvl, output int k);
    @(posedge clk);
    #2;
    in_level = lvl;
    k = cyc + 1;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int n0;
    n0   = done_cyc.size();
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (done_cyc.size() > n0) begin
        dcyc = done_cyc[n0];
        break;
      end
    end
    if (dcyc < 0) check_eq("done_timeout", 0, 1);
  endtask

  initial begin
    int k;
    int d;
    int d1;
    int d2;
    int bad;
    int g;
    int gmin;
    int gmax;
    logic lvl;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_out", out_signal, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_eq("idle_out", out_signal, 0);
    check_eq("idle_busy", busy, 0);

    // fixed gap 3, B=2, 0->1
    bounce_count = 3'd2;
    gap_len      = 6'd3;
    random_en    = 1'b0;
    clear_logs();
    start_level(1'b1, k);
    wait_done(200, d);
    check_eq("fix_nedges", edge_cyc.size(), 5);
    for (int i = 0; i < edge_cyc.size() && i < 5; i++)
      check_eq($sformatf("fix_edge%0d", i), edge_cyc[i] - k, 3 * i);
    check_eq("fix_final", out_signal, 1);
    check_eq("fix_done", d - k, 28);
    check_eq("fix_busy_rise", busy_rise - k, 0);
    check_eq("fix_busy_fall", busy_fall - k, 28);
    @(posedge clk);
    #2;
    check_eq("fix_done_1cyc", done, 0);
    check_eq("fix_busy_low", busy, 0);

    // B=0, 1->0: single edge
    bounce_count = 3'd0;
    clear_logs();
    start_level(1'b0, k);
    wait_done(100, d);
    check_eq("b0_nedges", edge_cyc.size(), 1);
    if (edge_cyc.size() > 0) check_eq("b0_edge", edge_cyc[0] - k, 0);
    check_eq("b0_done", d - k, 16);
    check_eq("b0_final", out_signal, 0);

    // sparse clock_enable (1 in 4), gap 2, B=1
    ce_sparse    = 1'b1;
    gap_len      = 6'd2;
    bounce_count = 3'd1;
    clear_logs();
    start_level(1'b1, k);
    wait_done(400, d);
    check_eq("sp_nedges", edge_cyc.size(), 3);
    if (edge_cyc.size() == 3) begin
      check_eq("sp_edge0", edge_cyc[0] - k, 0);
      check_eq("sp_gap", edge_cyc[2] - edge_cyc[1], 8);
      check_eq("sp_settle", d - edge_cyc[2], 64);
    end
    check_eq("sp_final", out_signal, 1);
    ce_sparse = 1'b0;

    // gap_len=0 behaves as 1, B=1, 1->0
    gap_len = 6'd0;
    clear_logs();
    start_level(1'b0, k);
    wait_done(100, d);
    check_eq("g0_nedges", edge_cyc.size(), 3);
    if (edge_cyc.size() == 3) check_eq("g0_last", edge_cyc[2] - k, 2);
    check_eq("g0_done", d - k, 18);

    // in_level changes during BOUNCE are ignored; leftover mismatch restarts
    gap_len      = 6'd3;
    bounce_count = 3'd2;
    clear_logs();
    start_level(1'b1, k);
    repeat (2) @(posedge clk);
    #2 in_level = 1'b0;
    repeat (2) @(posedge clk);
    #2 in_level = 1'b1;
    repeat (2) @(posedge clk);
    #2 in_level = 1'b0;
    wait_done(200, d1);
    check_eq("ign_done", d1 - k, 28);
    check_eq("ign_nedges", edge_cyc.size(), 5);
    if (edge_cyc.size() >= 5) begin
      check_eq("ign_last_edge", edge_cyc[4] - k, 12);
      check_eq("ign_target", edge_val[4], 1);
    end
    wait_done(200, d2);
    check_eq("ign_restart_n", edge_cyc.size(), 10);
    if (edge_cyc.size() >= 6) check_eq("ign_restart", edge_cyc[5] - d1, 1);
    check_eq("ign_done2", d2 - d1, 29);
    check_eq("ign_final2", out_signal, 0);

    // async reset mid-BOUNCE
    clear_logs();
    start_level(1'b1, k);
    repeat (2) @(posedge clk);
    #5;
    check_eq("ar_pre_out", out_signal, 1);
    check_eq("ar_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_eq("ar_out", out_signal, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_done", done, 0);
    repeat (4) @(posedge clk);
    #2;
    check_eq("ar_hold_out", out_signal, 0);
    check_eq("ar_hold_busy", busy, 0);
    in_level = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #2;
    check_eq("ar_no_edges", edge_cyc.size(), 0);

    // random gaps, B=7
    random_en    = 1'b1;
    bounce_count = 3'd7;
    gmin         = 1000;
    gmax         = 0;
    for (int t = 0; t < 40; t++) begin
      clear_logs();
      lvl = ~out_signal;
      start_level(lvl, k);
      wait_done(1200, d);
      check_eq($sformatf("rnd%0d_nedges", t), edge_cyc.size(), 15);
      bad = 0;
      for (int i = 1; i < edge_cyc.size(); i++) begin
        g = edge_cyc[i] - edge_cyc[i-1];
        if (g < 1 || g > 63) bad++;
        if (g < gmin) gmin = g;
        if (g > gmax) gmax = g;
      end
      check_eq($sformatf("rnd%0d_gap_range", t), bad, 0);
      check_eq($sformatf("rnd%0d_final", t), out_signal, lvl);
    end
    check_eq("rnd_gaps_vary", (gmin != gmax), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
